demux_1x8_bank: RTL

//  Write-side partner of the 8:1 selection mux: accepts indexed writes (idx, data)
//  and demultiplexes them into eight registered slots z0..z7 that feed the mux inputs.

---
 rtl/demux_bank_pkg.sv | 13 +
 rtl/small_sync_fifo.sv | 47 ++++
 rtl/demux_1x8_bank.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/demux_bank_pkg.sv
// Shared constants and FSM state type for the 1x8 write-side demux bank.
package demux_bank_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } state_e;

endpackage

// File: rtl/small_sync_fifo.sv
// In-order synchronous FIFO; push ignored when full, pop ignored when empty.
module small_sync_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             one_left_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Extra pointer MSB distinguishes full from empty.
  logic [PTR_W:0]   wr_q, rd_q;
  logic [PTR_W:0]   used;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign used       = wr_q - rd_q;
  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (used == (PTR_W+1)'(DEPTH));
  assign one_left_o = (used == (PTR_W+1)'(1));
  assign rdata_o    = mem_q[rd_q[PTR_W-1:0]];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/demux_1x8_bank.sv
// Buffered indexed writes into eight registered slots with an ordered bulk clear.
// Optional parity checking on commit is enabled by defining DEMUX_PARITY_EN.
module demux_1x8_bank
  import demux_bank_pkg::*;
#(
  parameter int unsigned W          = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [W-1:0]       in_data,
`ifdef DEMUX_PARITY_EN
  input  logic               in_par,
  output logic               par_err,
`endif
  input  logic               clr_req,
  output logic               clr_busy,
  output logic [W-1:0]       z0,
  output logic [W-1:0]       z1,
  output logic [W-1:0]       z2,
  output logic [W-1:0]       z3,
  output logic [W-1:0]       z4,
  output logic [W-1:0]       z5,
  output logic [W-1:0]       z6,
  output logic [W-1:0]       z7,
  output logic [NUM_SLOTS-1:0] slot_valid
);

`ifdef DEMUX_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned ENT_W = IDX_W + W + PAR_W;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]         z_q [NUM_SLOTS];
  logic [W-1:0]         z_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;

  logic [ENT_W-1:0]     fifo_wdata, fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_one_left;
  logic                 push, pop, par_ok;
  logic [IDX_W-1:0]     head_idx;
  logic [W-1:0]         head_data;

`ifdef DEMUX_PARITY_EN
  logic par_err_q, par_err_d;
  assign fifo_wdata = {in_idx, in_data, in_par};
  assign par_ok     = ~(^fifo_rdata[W:0]);
  assign par_err    = par_err_q;
`else
  assign fifo_wdata = {in_idx, in_data};
  assign par_ok     = 1'b1;
`endif

  assign head_idx  = fifo_rdata[ENT_W-1 -: IDX_W];
  assign head_data = fifo_rdata[ENT_W-IDX_W-1 -: W];

  // A push in the same cycle as clr_req is taken and committed before the sweep.
  assign in_ready = !fifo_full && (state_q == IDLE);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q != SWEEP) && !fifo_empty;
  assign clr_busy = (state_q != IDLE);

  small_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .wdata_i    (fifo_wdata),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .one_left_o (fifo_one_left)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    valid_d = valid_q;
`ifdef DEMUX_PARITY_EN
    par_err_d = par_err_q;
`endif

    if (pop && par_ok) begin
      z_d[head_idx]     = head_data;
      valid_d[head_idx] = 1'b1;
    end
`ifdef DEMUX_PARITY_EN
    if (pop && !par_ok) par_err_d = 1'b1;
`endif

    unique case (state_q)
      IDLE: begin
        // Drain only if something is still queued after this cycle's pop/push.
        if (clr_req) begin
          if (push || (!fifo_empty && !fifo_one_left)) state_d = DRAIN;
          else                                          state_d = SWEEP;
        end
      end
      DRAIN: begin
        if (fifo_empty || fifo_one_left) state_d = SWEEP;
      end
      SWEEP: begin
        z_d[cnt_q]     = '0;
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(NUM_SLOTS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef DEMUX_PARITY_EN
    if (state_d == SWEEP && state_q != SWEEP) par_err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) z_q[i] <= '0;
`ifdef DEMUX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      z_q     <= z_d;
`ifdef DEMUX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign z0 = z_q[0];
  assign z1 = z_q[1];
  assign z2 = z_q[2];
  assign z3 = z_q[3];
  assign z4 = z_q[4];
  assign z5 = z_q[5];
  assign z6 = z_q[6];
  assign z7 = z_q[7];
  assign slot_valid = valid_q;

endmodule
